// File: rtl/drs_trigger_gen.sv
// DRS4 trigger generator: off/periodic/external/burst trigger sources, pulse stretcher,
// busy lockout and accepted/missed counters. Define DRS_TRIG_SW_TRIG_EN to add the software trigger.
module drs_trigger_gen #(
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 4,
  parameter int N_EXT   = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [15:0]        burst_len,
  input  logic [PULSE_W-1:0] pulse_len,
  input  logic [N_EXT-1:0]   ext_trig_i,
  input  logic [N_EXT-1:0]   ext_mask,
  input  logic               busy_i,
  input  logic               sw_trig_i,
  input  logic               count_clr_i,
  output logic               dtrig_o,
  output logic               burst_done_o,
  output logic [31:0]        trig_count_o,
  output logic [31:0]        missed_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_PER   = 2'd1;
  localparam logic [1:0] M_EXT   = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           mode_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          bcnt_q, bcnt_d;
  logic [N_EXT-1:0]     ext_q;
  logic                 lvl_q, ext_req_q;
  logic                 dtrig_q, dtrig_d;
  logic [PULSE_W-1:0]   plen_q, plen_d;
  logic                 burst_done_q, burst_done_d;
  logic [31:0]          trig_cnt_q, trig_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;

  logic active, restart, run_ok, per_hit, burst_open, lvl;
  logic per_req, ext_req, sw_req, req, accept, refuse;

  assign active     = enable && (mode != M_OFF);
  assign restart    = (state_q != S_IDLE) && (mode != mode_q);
  assign run_ok     = (state_q == S_RUN) && active && !restart;
  assign per_hit    = (cnt_q == period);
  assign burst_open = (bcnt_q < burst_len);
  assign lvl        = |(ext_q & ext_mask);

  assign per_req = run_ok && per_hit && ((mode == M_PER) || ((mode == M_BURST) && burst_open));
  assign ext_req = run_ok && (mode == M_EXT) && ext_req_q;

`ifdef DRS_TRIG_SW_TRIG_EN
  assign sw_req = sw_trig_i && active && (state_q != S_IDLE);
`else
  logic unused_sw;
  assign sw_req    = 1'b0;
  assign unused_sw = sw_trig_i;
`endif

  // Coincident sources collapse into one request; refused requests never disturb the period phase.
  assign req    = per_req || ext_req || sw_req;
  assign accept = req && !busy_i && !dtrig_q;
  assign refuse = req && !accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    if (!active) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bcnt_d  = '0;
    end else if ((state_q == S_IDLE) || restart) begin
      state_d = S_RUN;
      cnt_d   = '0;
      bcnt_d  = '0;
    end else if (state_q == S_RUN) begin
      if ((mode == M_PER) || (mode == M_BURST))
        cnt_d = per_hit ? '0 : cnt_q + CNT_W'(1);
      if (mode == M_BURST) begin
        if (!burst_open) begin
          state_d = S_DONE;
        end else if (per_req && accept) begin
          bcnt_d = bcnt_q + 16'd1;
          if (bcnt_d == burst_len) state_d = S_DONE;
        end
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    dtrig_d      = dtrig_q;
    plen_d       = plen_q;
    trig_cnt_d   = trig_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    burst_done_d = (state_d == S_DONE);
    if (!active) begin
      dtrig_d = 1'b0;
    end else if (accept) begin
      dtrig_d = 1'b1;
      plen_d  = pulse_len;
    end else if (dtrig_q) begin
      if (plen_q == '0) dtrig_d = 1'b0;
      else              plen_d  = plen_q - PULSE_W'(1);
    end
    if (count_clr_i) begin
      trig_cnt_d = '0;
      miss_cnt_d = '0;
    end else begin
      if (accept) trig_cnt_d = trig_cnt_q + 32'd1;
      if (refuse) miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= S_IDLE;
      mode_q       <= M_OFF;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      ext_q        <= '0;
      lvl_q        <= 1'b0;
      ext_req_q    <= 1'b0;
      dtrig_q      <= 1'b0;
      plen_q       <= '0;
      burst_done_q <= 1'b0;
      trig_cnt_q   <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      ext_q        <= ext_trig_i;
      lvl_q        <= lvl;
      ext_req_q    <= lvl && !lvl_q;
      dtrig_q      <= dtrig_d;
      plen_q       <= plen_d;
      burst_done_q <= burst_done_d;
      trig_cnt_q   <= trig_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign dtrig_o        = dtrig_q;
  assign burst_done_o   = burst_done_q;
  assign trig_count_o   = trig_cnt_q;
  assign missed_count_o = miss_cnt_q;

endmodule
